// File: rtl/rate_spike_encoder.sv
// Rate-coded spike encoder: clamps a signed request to 0..WINDOW and streams that many evenly spread spikes over WINDOW timesteps.
// Optional spike counter output is enabled by defining RATE_ENCODER_COUNT_EN.
module rate_spike_encoder #(
    parameter int DATA_WIDTH = 16,
    parameter int WINDOW     = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [DATA_WIDTH-1:0] in_value,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  spike,
    output logic                  spike_valid,
    output logic                  done
`ifdef RATE_ENCODER_COUNT_EN
    ,
    output logic [CNT_WIDTH-1:0]  emitted_count
`endif
);

    localparam int V_W   = $clog2(WINDOW + 1);
    localparam int ACC_W = $clog2(2 * WINDOW) + 1;
    localparam int K_W   = $clog2(WINDOW);

    localparam logic [K_W-1:0]        K_LAST = K_W'(WINDOW - 1);
    localparam logic [K_W-1:0]        K_PEN  = K_W'(WINDOW - 2);
    localparam logic [ACC_W-1:0]      WIN_A  = ACC_W'(WINDOW);
    localparam logic [DATA_WIDTH-1:0] WIN_D  = DATA_WIDTH'(WINDOW);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ENCODE = 1'b1
    } state_t;

    function automatic logic [V_W-1:0] clamp_value(input logic [DATA_WIDTH-1:0] raw);
        logic [V_W-1:0] r;
        if (raw[DATA_WIDTH-1] == 1'b1) begin
            r = '0;
        end else if (raw > WIN_D) begin
            r = V_W'(WINDOW);
        end else begin
            r = V_W'(raw);
        end
        return r;
    endfunction

    // One timestep of the accumulator: MSB of the result is the spike, the rest is the new remainder.
    function automatic logic [ACC_W:0] acc_step(input logic [ACC_W-1:0] acc, input logic [V_W-1:0] v);
        logic [ACC_W-1:0] sum;
        logic [ACC_W:0]   r;
        sum = acc + ACC_W'(v);
        if (sum >= WIN_A) begin
            r = {1'b1, sum - WIN_A};
        end else begin
            r = {1'b0, sum};
        end
        return r;
    endfunction

    state_t           state_r, state_n;
    logic [K_W-1:0]   k_r, k_n;
    logic [V_W-1:0]   v_r, v_n;
    logic [ACC_W-1:0] acc_r, acc_n;
    logic             ready_r, ready_n;
    logic             spike_r, spike_n;
    logic             valid_r, valid_n;
    logic             done_r, done_n;
    logic [CNT_WIDTH-1:0] cnt_r, cnt_n;
    logic             accept_s;
    logic [V_W-1:0]   clamp_s;
    logic [ACC_W:0]   start_step_s;
    logic [ACC_W:0]   run_step_s;

    assign accept_s     = in_valid && ready_r;
    assign clamp_s      = clamp_value(in_value);
    assign start_step_s = acc_step('0, clamp_s);
    assign run_step_s   = acc_step(acc_r, v_r);

    // Next-state and next-output logic.
    always_comb begin
        state_n = state_r;
        k_n     = k_r;
        v_n     = v_r;
        acc_n   = acc_r;
        ready_n = ready_r;
        spike_n = 1'b0;
        valid_n = 1'b0;
        done_n  = 1'b0;
        cnt_n   = cnt_r;
        case (state_r)
            IDLE: begin
                ready_n = 1'b1;
                if (accept_s) begin
                    state_n = ENCODE;
                    k_n     = '0;
                    v_n     = clamp_s;
                    acc_n   = start_step_s[ACC_W-1:0];
                    spike_n = start_step_s[ACC_W];
                    valid_n = 1'b1;
                    ready_n = 1'b0;
                    cnt_n   = CNT_WIDTH'(start_step_s[ACC_W]);
                end else begin
                    state_n = IDLE;
                end
            end
            ENCODE: begin
                if (k_r == K_LAST) begin
                    // Done cycle: either restart immediately or fall back to idle.
                    if (accept_s) begin
                        k_n     = '0;
                        v_n     = clamp_s;
                        acc_n   = start_step_s[ACC_W-1:0];
                        spike_n = start_step_s[ACC_W];
                        valid_n = 1'b1;
                        ready_n = 1'b0;
                        cnt_n   = CNT_WIDTH'(start_step_s[ACC_W]);
                    end else begin
                        state_n = IDLE;
                        ready_n = 1'b1;
                    end
                end else begin
                    k_n     = k_r + K_W'(1);
                    acc_n   = run_step_s[ACC_W-1:0];
                    spike_n = run_step_s[ACC_W];
                    valid_n = 1'b1;
                    done_n  = (k_r == K_PEN);
                    ready_n = (k_r == K_PEN);
                    cnt_n   = cnt_r + CNT_WIDTH'(run_step_s[ACC_W]);
                end
            end
            default: begin
                state_n = IDLE;
                ready_n = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r <= IDLE;
            k_r     <= '0;
            v_r     <= '0;
            acc_r   <= '0;
            ready_r <= 1'b0;
            spike_r <= 1'b0;
            valid_r <= 1'b0;
            done_r  <= 1'b0;
            cnt_r   <= '0;
        end else begin
            state_r <= state_n;
            k_r     <= k_n;
            v_r     <= v_n;
            acc_r   <= acc_n;
            ready_r <= ready_n;
            spike_r <= spike_n;
            valid_r <= valid_n;
            done_r  <= done_n;
            cnt_r   <= cnt_n;
        end
    end

    assign in_ready    = ready_r;
    assign spike       = spike_r;
    assign spike_valid = valid_r;
    assign done        = done_r;
`ifdef RATE_ENCODER_COUNT_EN
    assign emitted_count = cnt_r;
`endif

endmodule
